// File: rtl/unidade_de_controle.sv
// ---------------------------------------------------------------------------
// unidade_de_controle -- SAP-1 control sequencer
//
// A one-hot ring (T1..T6) sequences the fetch phase (T1..T3) and the execute
// phase (T4..T6) of every instruction. A HLT opcode diverts the ring into a
// terminal HALT state that only CLR can leave. Every control strobe is a
// purely combinational decode of (state, opcode), gated by CLR.
//
// There is no handshake here. The datapath consumes the strobes in the same
// cycle they are asserted. The sequencer advances unconditionally, one state
// per rising CLK edge.
//
// Ports
//   CLK     in   1  system clock, rising edge
//   CLR     in   1  synchronous active-low reset (also gates all outputs low)
//   opcode  in   4  IR upper nibble, decoded live during T4..T6
//   Cp Ep Ej                          out  PC increment / drive bus / load
//   Eu Add Sub AndOp OrOp XorOp NotOp out  ALU drive bus and operation select
//   La Ea Lb                          out  accumulator load / drive, B load
//   Lm CE L1 Ei L0                    out  MAR load, RAM drive, IR load,
//                                          IR operand drive, output load
// ---------------------------------------------------------------------------
module unidade_de_controle (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] opcode,
  output logic       Cp,
  output logic       Ep,
  output logic       Ej,
  output logic       Eu,
  output logic       Add,
  output logic       Sub,
  output logic       AndOp,
  output logic       OrOp,
  output logic       XorOp,
  output logic       NotOp,
  output logic       La,
  output logic       Ea,
  output logic       Lb,
  output logic       Lm,
  output logic       CE,
  output logic       L1,
  output logic       Ei,
  output logic       L0
);

  typedef enum logic [6:0] {
    T1   = 7'b0000001,
    T2   = 7'b0000010,
    T3   = 7'b0000100,
    T4   = 7'b0001000,
    T5   = 7'b0010000,
    T6   = 7'b0100000,
    HALT = 7'b1000000
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_OUT = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1010;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Kept as a named signal so checkers can bind to the current ring position.
  state_t state;
  state_t state_next;

  // Two-operand ALU ops share the same memory-operand fetch in T4/T5.
  logic is_alu2;
  assign is_alu2 = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_OR)  ||
                   (opcode == OP_XOR);

  // State register
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state <= T1;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = T1;
    case (state)
      T1:      state_next = T2;
      T2:      state_next = T3;
      T3:      state_next = T4;
      // HLT leaves the ring right after its (empty) T4.
      T4:      state_next = (opcode == OP_HLT) ? HALT : T5;
      T5:      state_next = T6;
      T6:      state_next = T1;
      HALT:    state_next = HALT;
      default: state_next = T1;
    endcase
  end

  // Output decode. CLR low forces every strobe low, whatever the state.
  always_comb begin
    Cp    = 1'b0;
    Ep    = 1'b0;
    Ej    = 1'b0;
    Eu    = 1'b0;
    Add   = 1'b0;
    Sub   = 1'b0;
    AndOp = 1'b0;
    OrOp  = 1'b0;
    XorOp = 1'b0;
    NotOp = 1'b0;
    La    = 1'b0;
    Ea    = 1'b0;
    Lb    = 1'b0;
    Lm    = 1'b0;
    CE    = 1'b0;
    L1    = 1'b0;
    Ei    = 1'b0;
    L0    = 1'b0;
    if (CLR) begin
      case (state)
        T1: begin
          Ep = 1'b1;
          Lm = 1'b1;
        end
        T2: begin
          Cp = 1'b1;
        end
        T3: begin
          CE = 1'b1;
          L1 = 1'b1;
        end
        T4: begin
          if (opcode == OP_LDA || is_alu2) begin
            Ei = 1'b1;
            Lm = 1'b1;
          end else if (opcode == OP_OUT) begin
            Ea = 1'b1;
            L0 = 1'b1;
          end else if (opcode == OP_JMP) begin
            Ei = 1'b1;
            Ej = 1'b1;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            CE = 1'b1;
            La = 1'b1;
          end else if (is_alu2) begin
            CE = 1'b1;
            Lb = 1'b1;
          end
        end
        T6: begin
          if (is_alu2 || opcode == OP_NOT) begin
            Eu = 1'b1;
            La = 1'b1;
          end
          Add   = (opcode == OP_ADD);
          Sub   = (opcode == OP_SUB);
          AndOp = (opcode == OP_AND);
          OrOp  = (opcode == OP_OR);
          XorOp = (opcode == OP_XOR);
          NotOp = (opcode == OP_NOT);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_de_controle.sv
// ---------------------------------------------------------------------------
// tb_unidade_de_controle -- self-checking bench for the SAP-1 sequencer.
// The reference model tracks only "step within instruction" (0..5) and a
// halted flag, and looks expected strobes up in per-opcode tables.
// ---------------------------------------------------------------------------
module tb_unidade_de_controle;

  logic       CLK;
  logic       CLR;
  logic [3:0] opcode;
  logic Cp, Ep, Ej, Eu, Add, Sub, AndOp, OrOp, XorOp, NotOp;
  logic La, Ea, Lb, Lm, CE, L1, Ei, L0;

  unidade_de_controle dut (
    .CLK(CLK), .CLR(CLR), .opcode(opcode),
    .Cp(Cp), .Ep(Ep), .Ej(Ej), .Eu(Eu),
    .Add(Add), .Sub(Sub), .AndOp(AndOp), .OrOp(OrOp), .XorOp(XorOp), .NotOp(NotOp),
    .La(La), .Ea(Ea), .Lb(Lb), .Lm(Lm), .CE(CE), .L1(L1), .Ei(Ei), .L0(L0)
  );

  // Strobe vector, MSB first:
  // Cp Ep Ej Eu Add Sub AndOp OrOp XorOp NotOp La Ea Lb Lm CE L1 Ei L0
  localparam logic [17:0] M_CP  = 18'h20000;
  localparam logic [17:0] M_EP  = 18'h10000;
  localparam logic [17:0] M_EJ  = 18'h08000;
  localparam logic [17:0] M_EU  = 18'h04000;
  localparam logic [17:0] M_ADD = 18'h02000;
  localparam logic [17:0] M_SUB = 18'h01000;
  localparam logic [17:0] M_AND = 18'h00800;
  localparam logic [17:0] M_OR  = 18'h00400;
  localparam logic [17:0] M_XOR = 18'h00200;
  localparam logic [17:0] M_NOT = 18'h00100;
  localparam logic [17:0] M_LA  = 18'h00080;
  localparam logic [17:0] M_EA  = 18'h00040;
  localparam logic [17:0] M_LB  = 18'h00020;
  localparam logic [17:0] M_LM  = 18'h00010;
  localparam logic [17:0] M_CE  = 18'h00008;
  localparam logic [17:0] M_L1  = 18'h00004;
  localparam logic [17:0] M_EI  = 18'h00002;
  localparam logic [17:0] M_L0  = 18'h00001;

  logic [17:0] out_vec;
  assign out_vec = {Cp, Ep, Ej, Eu, Add, Sub, AndOp, OrOp, XorOp, NotOp,
                    La, Ea, Lb, Lm, CE, L1, Ei, L0};

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [17:0] fetch_tbl [3];
  logic [17:0] exec_tbl  [16][3];
  int          step   = 0;   // 0..5 within the current instruction
  bit          halted = 1'b0;

  initial begin
    fetch_tbl[0] = M_EP | M_LM;
    fetch_tbl[1] = M_CP;
    fetch_tbl[2] = M_CE | M_L1;
    for (int o = 0; o < 16; o++)
      for (int k = 0; k < 3; k++) exec_tbl[o][k] = '0;
    exec_tbl[0][0]  = M_EI | M_LM;  exec_tbl[0][1] = M_CE | M_LA;   // LDA
    exec_tbl[1][0]  = M_EA | M_L0;                                  // OUT
    for (int o = 4; o <= 8; o++) begin                              // ADD..XOR
      exec_tbl[o][0] = M_EI | M_LM;
      exec_tbl[o][1] = M_CE | M_LB;
    end
    exec_tbl[4][2]  = M_EU | M_LA | M_ADD;
    exec_tbl[5][2]  = M_EU | M_LA | M_SUB;
    exec_tbl[6][2]  = M_EU | M_LA | M_AND;
    exec_tbl[7][2]  = M_EU | M_LA | M_OR;
    exec_tbl[8][2]  = M_EU | M_LA | M_XOR;
    exec_tbl[9][2]  = M_EU | M_LA | M_NOT;                          // NOT
    exec_tbl[10][0] = M_EI | M_EJ;                                  // JMP
  end

  function automatic logic [17:0] model_out(input int s, input bit h,
                                            input logic clr, input logic [3:0] op);
    if (!clr || h) return '0;
    if (s < 3) return fetch_tbl[s];
    return exec_tbl[op][s - 3];
  endfunction

  // Model advances on every rising edge using the inputs that were stable there.
  always @(posedge CLK) begin
    if (!CLR) begin
      step   = 0;
      halted = 1'b0;
    end else if (!halted) begin
      if (step == 3 && opcode == 4'hF) halted = 1'b1;
      else step = (step + 1) % 6;
    end
  end

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q [$];

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      logic [17:0] e;
      e = exp_q.pop_front();
      checks++;
      if (out_vec !== e) begin
        failures++;
        $display("FAIL model t=%0t step=%0d halted=%0b op=%h clr=%0b got=%h want=%h",
                 $time, step, halted, opcode, CLR, out_vec, e);
      end
    end
  end

  // ---------------- driver ----------------
  // One cycle: after the rising edge apply inputs, queue the model's
  // expectation, and optionally pin the outputs to a hand-derived literal.
  task automatic cyc(input logic clr, input logic [3:0] op,
                     input bit pin, input logic [17:0] lit, input string name);
    @(posedge CLK);
    #2;
    CLR    = clr;
    opcode = op;
    exp_q.push_back(model_out(step, halted, clr, op));
    @(negedge CLK);
    #1;
    if (pin) begin
      checks++;
      if (out_vec !== lit) begin
        failures++;
        $display("FAIL %s got=%h want=%h", name, out_vec, lit);
      end
    end
  endtask

  task automatic run_fetch(input logic [3:0] op, input string tag);
    cyc(1'b1, op, 1'b1, M_EP | M_LM, {tag, "_t1"});
    cyc(1'b1, op, 1'b1, M_CP,        {tag, "_t2"});
    cyc(1'b1, op, 1'b1, M_CE | M_L1, {tag, "_t3"});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] rop;
    logic       rclr;
    CLR    = 1'b0;
    opcode = 4'h0;

    // Reset held for two edges: everything low.
    cyc(1'b0, 4'h4, 1'b1, '0, "rst_edge1");
    cyc(1'b0, 4'h4, 1'b1, '0, "rst_edge2");

    // ADD after release. First cycle with CLR high is still T1.
    run_fetch(4'h4, "add");
    cyc(1'b1, 4'h4, 1'b1, M_EI | M_LM,         "add_t4");
    cyc(1'b1, 4'h4, 1'b1, M_CE | M_LB,         "add_t5");
    cyc(1'b1, 4'h4, 1'b1, M_EU | M_ADD | M_LA, "add_t6");

    // SUB: only Sub in T6.
    run_fetch(4'h5, "sub");
    cyc(1'b1, 4'h5, 1'b1, M_EI | M_LM,         "sub_t4");
    cyc(1'b1, 4'h5, 1'b1, M_CE | M_LB,         "sub_t5");
    cyc(1'b1, 4'h5, 1'b1, M_EU | M_SUB | M_LA, "sub_t6");

    // XOR T6.
    run_fetch(4'h8, "xor");
    cyc(1'b1, 4'h8, 1'b0, '0, "");
    cyc(1'b1, 4'h8, 1'b0, '0, "");
    cyc(1'b1, 4'h8, 1'b1, M_EU | M_XOR | M_LA, "xor_t6");

    // NOT: T4/T5 empty, T6 Eu NotOp La.
    run_fetch(4'h9, "not");
    cyc(1'b1, 4'h9, 1'b1, '0,                  "not_t4");
    cyc(1'b1, 4'h9, 1'b1, '0,                  "not_t5");
    cyc(1'b1, 4'h9, 1'b1, M_EU | M_NOT | M_LA, "not_t6");

    // JMP: T4 Ei Ej, then nothing.
    run_fetch(4'hA, "jmp");
    cyc(1'b1, 4'hA, 1'b1, M_EI | M_EJ, "jmp_t4");
    cyc(1'b1, 4'hA, 1'b1, '0,          "jmp_t5");
    cyc(1'b1, 4'hA, 1'b1, '0,          "jmp_t6");

    // LDA then OUT.
    run_fetch(4'h0, "lda");
    cyc(1'b1, 4'h0, 1'b1, M_EI | M_LM, "lda_t4");
    cyc(1'b1, 4'h0, 1'b1, M_CE | M_LA, "lda_t5");
    cyc(1'b1, 4'h0, 1'b1, '0,          "lda_t6");
    run_fetch(4'h1, "out");
    cyc(1'b1, 4'h1, 1'b1, M_EA | M_L0, "out_t4");
    cyc(1'b1, 4'h1, 1'b1, '0,          "out_t5");
    cyc(1'b1, 4'h1, 1'b1, '0,          "out_t6");

    // HLT: silent from T4 onward, even if the opcode wanders.
    run_fetch(4'hF, "hlt");
    cyc(1'b1, 4'hF, 1'b1, '0, "hlt_t4");
    for (int i = 0; i < 12; i++)
      cyc(1'b1, (i % 2 == 0) ? 4'h4 : 4'hF, 1'b1, '0, "hlt_hold");
    cyc(1'b0, 4'h4, 1'b1, '0, "hlt_clr");
    cyc(1'b1, 4'h4, 1'b1, M_EP | M_LM, "hlt_resume_t1");
    cyc(1'b1, 4'h4, 1'b1, M_CP,        "hlt_resume_t2");
    cyc(1'b1, 4'h4, 1'b0, '0, "");
    cyc(1'b1, 4'h4, 1'b0, '0, "");
    cyc(1'b1, 4'h4, 1'b0, '0, "");
    cyc(1'b1, 4'h4, 1'b0, '0, "");

    // Reset asserted during T5 of ADD: no T6 pulse, back to T1.
    run_fetch(4'h4, "mid");
    cyc(1'b1, 4'h4, 1'b1, M_EI | M_LM, "mid_t4");
    cyc(1'b0, 4'h4, 1'b1, '0,          "mid_t5_clr");
    cyc(1'b1, 4'h4, 1'b1, M_EP | M_LM, "mid_after_t1");
    cyc(1'b1, 4'h4, 1'b1, M_CP,        "mid_after_t2");

    // Randomized: opcode changes occasionally (even mid-instruction),
    // sporadic resets rescue HALT.
    rop = 4'h4;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rop = 4'($urandom_range(0, 15));
      rclr = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      cyc(rclr, rop, 1'b0, '0, "");
    end

    @(posedge CLK);
    @(negedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
